alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter STARVE_MAX, default 4, consecutive denied accelerator cycles before forced accelerator grant.
REQ-003 Parameter LOCK_MAX, default 8, maximum back-to-back locked accelerator grants.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 core_req  in  1  pipeline requests an ALU operation this cycle.
REQ-007 core_ctrl / core_a / core_b  in  6 / DATA_WIDTH / DATA_WIDTH  core ALU control code and operands.
REQ-008 core_gnt  out  1  core operands accepted this cycle (combinational).
REQ-009 core_rvalid  out  1  rdata/rbranch belong to core this cycle.
REQ-010 acc_req  in  1  encryption accelerator requests an ALU operation.
REQ-011 acc_ctrl / acc_a / acc_b  in  6 / DATA_WIDTH / DATA_WIDTH  accelerator control code and operands.
REQ-012 acc_lock  in  1  accelerator requests exclusive back-to-back ownership.
REQ-013 acc_gnt  out  1  accelerator operands accepted this cycle (combinational).
REQ-014 acc_rvalid  out  1  rdata/rbranch belong to accelerator this cycle.
REQ-015 rdata  out  DATA_WIDTH  registered ALU result.
REQ-016 rbranch  out  1  registered ALU branch-taken flag.
REQ-017 stall_core  out  1  core_req high and core_gnt low (combinational).
REQ-018 alu_ctrl / alu_a / alu_b  out  6 / DATA_WIDTH / DATA_WIDTH  registered drive to shared ALU.
REQ-019 alu_result / alu_branch  in  DATA_WIDTH / 1  shared ALU combinational outputs.

Function
REQ-020 At most one of core_gnt, acc_gnt SHALL be high in any cycle; a grant SHALL only be given to a requester whose req is high.
REQ-021 Pipeline: grant in cycle N latches ctrl/operands into alu_* at edge N; ALU evaluates in N+1; alu_result/alu_branch captured at edge N+1; matching rvalid high for exactly cycle N+2.
REQ-022 Throughput SHALL be one grant per cycle; stages advance unconditionally (no backpressure on results).
REQ-023 Cycles with no grant SHALL load alu_ctrl=6'b111111, alu_a=alu_b=0 and clear the stage owner tag; no rvalid two cycles later.
REQ-024 FSM states ARB and LOCKED; reset state ARB.
REQ-025 ARB, only one req: that requester granted.
REQ-026 ARB, both req, starve_cnt<STARVE_MAX: core granted, starve_cnt increments (saturating at STARVE_MAX).
REQ-027 ARB, both req, starve_cnt==STARVE_MAX: accelerator granted.
REQ-028 starve_cnt SHALL clear on any acc_gnt or whenever acc_req is low.
REQ-029 ARB -> LOCKED when acc_gnt and acc_lock both high; lock_cnt loaded with 1.
REQ-030 LOCKED: accelerator granted every cycle acc_req and acc_lock are high and lock_cnt<LOCK_MAX; core denied; lock_cnt increments per grant.
REQ-031 LOCKED -> ARB when acc_req low, acc_lock low, or lock_cnt==LOCK_MAX; in the exit cycle the grant follows ARB rules, except after LOCK_MAX exit core SHALL win if core_req high.
REQ-032 Operand/result registers SHALL not depend on the non-granted requester's inputs.

Reset
REQ-033 While rst_n low at an edge: state=ARB, starve_cnt=0, lock_cnt=0, both stage owner tags cleared, alu_ctrl=6'b111111, alu_a=alu_b=0, rdata=0, rbranch=0.
REQ-034 core_rvalid/acc_rvalid SHALL be 0 the cycle after reset edge; in-flight operations are discarded, never reported.
REQ-035 core_gnt/acc_gnt SHALL be 0 while rst_n is low.

Verification
REQ-036 core_req only, core_ctrl=6'b000000, a=5, b=7 in cycle 0 -> core_gnt=1 cycle 0, alu_ctrl=0 cycle 1, core_rvalid=1 rdata=12 cycle 2.
REQ-037 Both req held every cycle, no lock, STARVE_MAX=4 -> grants core,core,core,core,acc, repeating; stall_core=1 on acc cycles.
REQ-038 acc_lock=1 with both req held, LOCK_MAX=8 -> 8 consecutive acc_gnt, then core_gnt next cycle.
REQ-039 Back-to-back core ADD then acc SUB (6'b001000, 9-3) -> core_rvalid cycle 2, acc_rvalid rdata=6 cycle 3, no overlap.
REQ-040 Branch op 6'b010000, a=b=4 -> rbranch=1 with rvalid cycle 2.
REQ-041 rst_n low in cycle 1 after grant in cycle 0 -> no rvalid in cycles 2-3, outputs at reset values.

Source files
------------

// File: rtl/alu_arbiter.sv
// Arbitrates a core pipeline and an encryption accelerator onto one shared ALU.
// Latency: grant in cycle N, result with owner's rvalid in cycle N+2.
// No result backpressure; requesters see backpressure only as a low grant.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req,
    input  logic [5:0]            core_ctrl,
    input  logic [DATA_WIDTH-1:0] core_a,
    input  logic [DATA_WIDTH-1:0] core_b,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    input  logic                  acc_req,
    input  logic [5:0]            acc_ctrl,
    input  logic [DATA_WIDTH-1:0] acc_a,
    input  logic [DATA_WIDTH-1:0] acc_b,
    input  logic                  acc_lock,
    output logic                  acc_gnt,
    output logic                  acc_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rbranch,
    output logic                  stall_core,
    output logic [5:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_branch
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [5:0] CTRL_NOP = 6'b111111;

    typedef enum logic {ARB, LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_ACC} owner_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;
    owner_t        s1_owner, s2_owner;
    logic          lock_hold, lock_expired;

    assign lock_hold    = (state == LOCKED) && acc_req && acc_lock && (lock_cnt < LW'(LOCK_MAX));
    assign lock_expired = (state == LOCKED) && (lock_cnt == LW'(LOCK_MAX));

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_cnt;
        core_gnt  = 1'b0;
        acc_gnt   = 1'b0;
        if (rst_n) begin
            if (lock_hold) begin
                acc_gnt  = 1'b1;
                lock_nxt = lock_cnt + LW'(1);
            end else begin
                // A lock that ran to its limit hands the next slot to a waiting core.
                if (lock_expired && core_req) begin
                    core_gnt = 1'b1;
                end else if (core_req && acc_req) begin
                    acc_gnt  = (starve_cnt == SW'(STARVE_MAX));
                    core_gnt = !acc_gnt;
                end else begin
                    core_gnt = core_req;
                    acc_gnt  = acc_req;
                end
                if (acc_gnt && acc_lock) begin
                    state_nxt = LOCKED;
                    lock_nxt  = LW'(1);
                end else begin
                    state_nxt = ARB;
                    lock_nxt  = '0;
                end
            end
        end
        starve_nxt = starve_cnt;
        if (!acc_req || acc_gnt)
            starve_nxt = '0;
        else if (starve_cnt < SW'(STARVE_MAX))
            starve_nxt = starve_cnt + SW'(1);
    end

    assign stall_core  = core_req && !core_gnt;
    assign core_rvalid = (s2_owner == OWN_CORE);
    assign acc_rvalid  = (s2_owner == OWN_ACC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            s1_owner   <= OWN_NONE;
            s2_owner   <= OWN_NONE;
            alu_ctrl   <= CTRL_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            rdata      <= '0;
            rbranch    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lock_cnt   <= lock_nxt;
            if (core_gnt) begin
                s1_owner <= OWN_CORE;
                alu_ctrl <= core_ctrl;
                alu_a    <= core_a;
                alu_b    <= core_b;
            end else if (acc_gnt) begin
                s1_owner <= OWN_ACC;
                alu_ctrl <= acc_ctrl;
                alu_a    <= acc_a;
                alu_b    <= acc_b;
            end else begin
                s1_owner <= OWN_NONE;
                alu_ctrl <= CTRL_NOP;
                alu_a    <= '0;
                alu_b    <= '0;
            end
            s2_owner <= s1_owner;
            // Result regs hold between owned operations so idle slots leave rdata stable.
            if (s1_owner != OWN_NONE) begin
                rdata   <= alu_result;
                rbranch <= alu_branch;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int SMAX = 4;
    localparam int LMAX = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req = 1'b0, acc_req = 1'b0, acc_lock = 1'b0;
    logic [5:0]    core_ctrl = '0, acc_ctrl = '0;
    logic [DW-1:0] core_a = '0, core_b = '0, acc_a = '0, acc_b = '0;
    logic          core_gnt, acc_gnt, core_rvalid, acc_rvalid, rbranch, stall_core;
    logic [DW-1:0] rdata, alu_a, alu_b, alu_result;
    logic [5:0]    alu_ctrl;
    logic          alu_branch;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_ctrl(core_ctrl), .core_a(core_a), .core_b(core_b),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .acc_req(acc_req), .acc_ctrl(acc_ctrl), .acc_a(acc_a), .acc_b(acc_b),
        .acc_lock(acc_lock), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
        .rdata(rdata), .rbranch(rbranch), .stall_core(stall_core),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_branch(alu_branch)
    );

    // Shared ALU as seen by the arbiter: add, sub, branch-if-equal, xor otherwise.
    function automatic logic [DW-1:0] ref_res(input logic [5:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (c)
            6'b000000: return a + b;
            6'b001000: return a - b;
            6'b010000: return a - b;
            default:   return a ^ b;
        endcase
    endfunction

    function automatic logic ref_br(input logic [5:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (c == 6'b010000) && (a == b);
    endfunction

    assign alu_result = ref_res(alu_ctrl, alu_a, alu_b);
    assign alu_branch = ref_br(alu_ctrl, alu_a, alu_b);

    // Reference model: who owns the ALU, how long the accelerator has waited,
    // and how long the current locked burst has run.
    int            m_starve = 0, m_lockrun = 0;
    bit            m_locked = 0;
    int            p1_own = 0, p2_own = 0;
    logic [5:0]    p1_ctrl = 6'h3F;
    logic [DW-1:0] p1_a = '0, p1_b = '0, p2_data = '0;
    logic          p2_br = 1'b0;

    logic          exp_core_gnt, exp_acc_gnt, exp_stall, exp_core_rv, exp_acc_rv, exp_rbranch;
    logic [DW-1:0] exp_rdata, exp_alu_a, exp_alu_b;
    logic [5:0]    exp_alu_ctrl;

    task automatic step(input bit rst, input bit cr, input logic [5:0] cc, input logic [DW-1:0] ca,
                        input logic [DW-1:0] cb, input bit ar, input logic [5:0] ac,
                        input logic [DW-1:0] aa, input logic [DW-1:0] ab, input bit al);
        int  winner;
        bit  cont;
        @(negedge clk);
        rst_n = rst; core_req = cr; core_ctrl = cc; core_a = ca; core_b = cb;
        acc_req = ar; acc_ctrl = ac; acc_a = aa; acc_b = ab; acc_lock = al;
        #1;
        cont = m_locked && ar && al && (m_lockrun < LMAX);
        if (!rst)                                     winner = 0;
        else if (cont)                                winner = 2;
        else if (m_locked && m_lockrun == LMAX && cr) winner = 1;
        else if (cr && ar)                            winner = (m_starve >= SMAX) ? 2 : 1;
        else                                          winner = cr ? 1 : (ar ? 2 : 0);
        exp_core_gnt = (winner == 1);
        exp_acc_gnt  = (winner == 2);
        exp_stall    = cr && (winner != 1);
        exp_core_rv  = (p2_own == 1);
        exp_acc_rv   = (p2_own == 2);
        exp_rdata    = p2_data;
        exp_rbranch  = p2_br;
        exp_alu_ctrl = p1_ctrl;
        exp_alu_a    = p1_a;
        exp_alu_b    = p1_b;
        if (!rst) begin
            m_starve = 0; m_lockrun = 0; m_locked = 0;
            p1_own = 0; p1_ctrl = 6'h3F; p1_a = '0; p1_b = '0;
            p2_own = 0; p2_data = '0; p2_br = 1'b0;
        end else begin
            if (p1_own != 0) begin
                p2_data = ref_res(p1_ctrl, p1_a, p1_b);
                p2_br   = ref_br(p1_ctrl, p1_a, p1_b);
            end
            p2_own = p1_own;
            p1_own = winner;
            case (winner)
                1:       begin p1_ctrl = cc;    p1_a = ca; p1_b = cb; end
                2:       begin p1_ctrl = ac;    p1_a = aa; p1_b = ab; end
                default: begin p1_ctrl = 6'h3F; p1_a = '0; p1_b = '0; end
            endcase
            m_starve = (ar && winner != 2) ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
            if (winner == 2 && al) begin
                m_lockrun = cont ? m_lockrun + 1 : 1;
                m_locked  = 1;
            end else begin
                m_lockrun = 0;
                m_locked  = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        step(0, 1, 6'h00, 1, 2, 1, 6'h08, 3, 4, 1);
        tests++; if (core_gnt !== 1'b0) begin fails++; $display("FAIL reset_core_gnt: got %b want 0", core_gnt); end
        tests++; if (acc_gnt !== 1'b0) begin fails++; $display("FAIL reset_acc_gnt: got %b want 0", acc_gnt); end
        step(0, 1, 6'h00, 1, 2, 1, 6'h08, 3, 4, 1);
        tests++; if ({core_rvalid, acc_rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b want 00", {core_rvalid, acc_rvalid}); end
        tests++; if (alu_ctrl !== 6'h3F || alu_a !== '0 || alu_b !== '0) begin fails++; $display("FAIL reset_alu: got ctrl=%h a=%h b=%h want 3f/0/0", alu_ctrl, alu_a, alu_b); end
        tests++; if (rdata !== '0 || rbranch !== 1'b0) begin fails++; $display("FAIL reset_result: got rdata=%h rbranch=%b want 0/0", rdata, rbranch); end
        idle(1);
    endtask

    task automatic test_core_add;
        step(1, 1, 6'b000000, 5, 7, 0, 0, 0, 0, 0);
        tests++; if (core_gnt !== 1'b1 || acc_gnt !== 1'b0) begin fails++; $display("FAIL core_add_gnt: got core=%b acc=%b want 1/0", core_gnt, acc_gnt); end
        idle(1);
        tests++; if (alu_ctrl !== 6'b000000 || alu_a !== 32'd5 || alu_b !== 32'd7) begin fails++; $display("FAIL core_add_alu: got ctrl=%h a=%0d b=%0d want 0/5/7", alu_ctrl, alu_a, alu_b); end
        idle(1);
        tests++; if (core_rvalid !== 1'b1 || acc_rvalid !== 1'b0 || rdata !== 32'd12) begin fails++; $display("FAIL core_add_result: got crv=%b arv=%b rdata=%0d want 1/0/12", core_rvalid, acc_rvalid, rdata); end
        idle(1);
        tests++; if (core_rvalid !== 1'b0) begin fails++; $display("FAIL core_add_single_rvalid: got %b want 0", core_rvalid); end
    endtask

    task automatic test_starve;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 6'h00, i, 1, 1, 6'h08, 100, i, 0);
            tests++;
            if (core_gnt !== (i % 5 != 4) || acc_gnt !== (i % 5 == 4) || stall_core !== (i % 5 == 4)) begin
                fails++; $display("FAIL starve_pattern[%0d]: got core=%b acc=%b stall=%b want %b/%b/%b", i, core_gnt, acc_gnt, stall_core, i % 5 != 4, i % 5 == 4, i % 5 == 4);
            end
        end
        idle(3);
    endtask

    task automatic test_lock;
        logic want_acc;
        for (int i = 0; i < 13; i++) begin
            step(1, 1, 6'h00, 1, 1, 1, 6'h08, 9, 3, 1);
            want_acc = (i >= 4 && i < 12);
            tests++;
            if (acc_gnt !== want_acc || core_gnt !== !want_acc) begin
                fails++; $display("FAIL lock_burst[%0d]: got core=%b acc=%b want %b/%b", i, core_gnt, acc_gnt, !want_acc, want_acc);
            end
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        step(1, 1, 6'b000000, 5, 7, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 6'b001000, 9, 3, 0);
        tests++; if (acc_gnt !== 1'b1 || core_gnt !== 1'b0) begin fails++; $display("FAIL b2b_acc_gnt: got core=%b acc=%b want 0/1", core_gnt, acc_gnt); end
        idle(1);
        tests++; if (core_rvalid !== 1'b1 || acc_rvalid !== 1'b0 || rdata !== 32'd12) begin fails++; $display("FAIL b2b_core_result: got crv=%b arv=%b rdata=%0d want 1/0/12", core_rvalid, acc_rvalid, rdata); end
        idle(1);
        tests++; if (acc_rvalid !== 1'b1 || core_rvalid !== 1'b0 || rdata !== 32'd6) begin fails++; $display("FAIL b2b_acc_result: got crv=%b arv=%b rdata=%0d want 0/1/6", core_rvalid, acc_rvalid, rdata); end
        idle(1);
        tests++; if ({core_rvalid, acc_rvalid} !== 2'b00) begin fails++; $display("FAIL b2b_drain: got %b want 00", {core_rvalid, acc_rvalid}); end
    endtask

    task automatic test_branch;
        step(1, 1, 6'b010000, 4, 4, 0, 0, 0, 0, 0);
        idle(2);
        tests++; if (core_rvalid !== 1'b1 || rbranch !== 1'b1) begin fails++; $display("FAIL branch_taken: got crv=%b rbranch=%b want 1/1", core_rvalid, rbranch); end
        idle(1);
    endtask

    task automatic test_reset_midflight;
        step(1, 1, 6'b000000, 1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++; if ({core_rvalid, acc_rvalid} !== 2'b00 || rdata !== '0 || rbranch !== 1'b0 || alu_ctrl !== 6'h3F) begin
            fails++; $display("FAIL midflight_c2: got rv=%b rdata=%h rbranch=%b ctrl=%h want 00/0/0/3f", {core_rvalid, acc_rvalid}, rdata, rbranch, alu_ctrl);
        end
        idle(1);
        tests++; if ({core_rvalid, acc_rvalid} !== 2'b00 || rdata !== '0) begin fails++; $display("FAIL midflight_c3: got rv=%b rdata=%h want 00/0", {core_rvalid, acc_rvalid}, rdata); end
    endtask

    function automatic logic [5:0] rand_ctrl();
        case ($urandom_range(0, 3))
            0:       return 6'b000000;
            1:       return 6'b001000;
            2:       return 6'b010000;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic test_random;
        bit            rst, cr, ar, al;
        logic [DW-1:0] ca, cb, aa, ab;
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            cr  = ($urandom_range(0, 3) != 0);
            ar  = ($urandom_range(0, 2) != 0);
            al  = ($urandom_range(0, 3) != 0);
            ca  = $urandom_range(0, 3); cb = $urandom_range(0, 3);
            aa  = $urandom;             ab = $urandom;
            step(rst, cr, rand_ctrl(), ca, cb, ar, rand_ctrl(), aa, ab, al);
            tests++; if (core_gnt !== exp_core_gnt || acc_gnt !== exp_acc_gnt || stall_core !== exp_stall) begin
                fails++; $display("FAIL rand_gnt[%0d]: got core=%b acc=%b stall=%b want %b/%b/%b", i, core_gnt, acc_gnt, stall_core, exp_core_gnt, exp_acc_gnt, exp_stall);
            end
            tests++; if (core_rvalid !== exp_core_rv || acc_rvalid !== exp_acc_rv) begin
                fails++; $display("FAIL rand_rvalid[%0d]: got crv=%b arv=%b want %b/%b", i, core_rvalid, acc_rvalid, exp_core_rv, exp_acc_rv);
            end
            tests++; if (rdata !== exp_rdata || rbranch !== exp_rbranch) begin
                fails++; $display("FAIL rand_result[%0d]: got rdata=%h rbranch=%b want %h/%b", i, rdata, rbranch, exp_rdata, exp_rbranch);
            end
            tests++; if (alu_ctrl !== exp_alu_ctrl || alu_a !== exp_alu_a || alu_b !== exp_alu_b) begin
                fails++; $display("FAIL rand_alu[%0d]: got %h/%h/%h want %h/%h/%h", i, alu_ctrl, alu_a, alu_b, exp_alu_ctrl, exp_alu_a, exp_alu_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_core_add();
        test_starve();
        test_lock();
        test_back_to_back();
        test_branch();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
